dense_layer: RTL and testbench

Fully-connected layer stage, y = W·x + b, in signed fixed point. It sits directly upstream of the relu stage in the example MLP and drives the relu vec_in array. One MAC lane per output neuron; the lanes walk the input vector one element per cycle. Weights come from an external combinational-read ROM, one column per cycle. Start/busy/done handshake to the layer sequencer.

---
 rtl/mlp_pkg.sv | 42 ++++
 rtl/mac_lane.sv | 51 +++++
 rtl/dense_layer.sv | 135 +++++++++++++
 tb/tb_dense_layer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP datapath: FSM states, width helpers and result narrowing.
// Narrowing saturates when DENSE_SAT_EN is defined, otherwise wraps to the low DATA_W bits.
package mlp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FIN,
    S_DONE
  } state_e;

  // Working width for narrow(); must cover the widest accumulator in use.
  localparam int unsigned NarrowW = 256;

  function automatic int unsigned acc_w(int unsigned data_w, int unsigned in_dim);
    return 2 * data_w + $clog2(in_dim) + 1;
  endfunction

  function automatic int unsigned addr_w(int unsigned in_dim);
    return (in_dim > 1) ? $clog2(in_dim) : 1;
  endfunction

  // Returns r narrowed to data_w bits, sign-extended back to NarrowW.
  function automatic logic signed [NarrowW-1:0] narrow(logic signed [NarrowW-1:0] r,
                                                       int unsigned data_w);
`ifdef DENSE_SAT_EN
    logic signed [NarrowW-1:0] hi;
    logic signed [NarrowW-1:0] lo;
    hi = (NarrowW'(1) <<< (data_w - 1)) - NarrowW'(1);
    lo = ~hi;
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
`else
    return (r <<< (NarrowW - data_w)) >>> (NarrowW - data_w);
`endif
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One output neuron: signed multiply-accumulate over the input vector, then bias add,
// fixed-point rescale and narrowing to DATA_W.
module mac_lane
  import mlp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_DIM = 4,
  parameter int unsigned FRAC_W = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] res_o
);

  localparam int unsigned AccW = acc_w(DATA_W, IN_DIM);

  logic signed [AccW-1:0]     acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [AccW-1:0]     sum;
  logic signed [AccW-1:0]     scaled;

  assign prod = $signed(x_i) * $signed(w_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AccW'(prod);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Bias is aligned to the product's fractional point before the floor shift.
  assign sum    = acc_q + (AccW'($signed(bias_i)) <<< FRAC_W);
  assign scaled = sum >>> FRAC_W;
  assign res_o  = DATA_W'(narrow(NarrowW'(scaled), DATA_W));

endmodule

// File: rtl/dense_layer.sv
// Fully-connected layer y = W*x + b with one MAC lane per output neuron.
// Build option DENSE_SAT_EN selects saturating (defined) or wrapping (undefined) narrowing.
module dense_layer
  import mlp_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IN_DIM  = 4,
  parameter int unsigned OUT_DIM = 4,
  parameter int unsigned FRAC_W  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IN_DIM*DATA_W-1:0]    vec_in,
  input  logic [OUT_DIM*DATA_W-1:0]   bias,
  output logic [addr_w(IN_DIM)-1:0]   w_addr,
  input  logic [OUT_DIM*DATA_W-1:0]   w_col,
  output logic                        busy,
  output logic                        done,
  output logic [OUT_DIM*DATA_W-1:0]   vec_out
);

  localparam int unsigned        AddrW   = addr_w(IN_DIM);
  localparam logic [AddrW-1:0]   LastIdx = AddrW'(IN_DIM - 1);

  state_e                      state_q, state_d;
  logic [AddrW-1:0]            idx_q, idx_d;
  logic [DATA_W-1:0]           x_q [IN_DIM];
  logic [DATA_W-1:0]           x_d [IN_DIM];
  logic [OUT_DIM*DATA_W-1:0]   vec_out_q, vec_out_d;
  logic [OUT_DIM*DATA_W-1:0]   res;
  logic [DATA_W-1:0]           x_cur;
  logic                        acc_clr, acc_en, out_ld;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (idx_q == LastIdx) state_d = S_FIN;
      S_FIN:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_addr  = '0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    out_ld  = 1'b0;
    unique case (state_q)
      S_IDLE: acc_clr = start;
      S_MAC: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        w_addr = idx_q;
      end
      S_FIN: begin
        busy   = 1'b1;
        out_ld = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    x_d       = x_q;
    vec_out_d = vec_out_q;
    if (acc_clr) begin
      idx_d = '0;
      for (int i = 0; i < int'(IN_DIM); i++) begin
        x_d[i] = vec_in[i*DATA_W +: DATA_W];
      end
    end else if (acc_en) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + AddrW'(1);
    end
    if (out_ld) begin
      vec_out_d = res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      x_q       <= '{default: '0};
      vec_out_q <= '0;
    end else begin
      idx_q     <= idx_d;
      x_q       <= x_d;
      vec_out_q <= vec_out_d;
    end
  end

  assign vec_out = vec_out_q;

  always_comb begin
    x_cur = '0;
    for (int i = 0; i < int'(IN_DIM); i++) begin
      if (idx_q == AddrW'(i)) x_cur = x_q[i];
    end
  end

  for (genvar k = 0; k < int'(OUT_DIM); k++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .IN_DIM (IN_DIM),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (acc_clr),
      .en_i   (acc_en),
      .x_i    (x_cur),
      .w_i    (w_col[k*DATA_W +: DATA_W]),
      .bias_i (bias[k*DATA_W +: DATA_W]),
      .res_o  (res[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer: four instances cover the basic, fixed-point,
// narrowing and default-size configurations.
module tb_dense_layer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // A: DATA_W=16, IN=2, OUT=2, FRAC=0
  logic        start_a, busy_a, done_a;
  logic [31:0] vec_in_a, bias_a, w_col_a, vec_out_a;
  logic [0:0]  w_addr_a;
  // B: DATA_W=16, IN=1, OUT=1, FRAC=4
  logic        start_b, busy_b, done_b;
  logic [15:0] vec_in_b, bias_b, w_col_b, vec_out_b;
  logic [0:0]  w_addr_b;
  // C: DATA_W=8, IN=2, OUT=1, FRAC=0
  logic        start_c, busy_c, done_c;
  logic [15:0] vec_in_c;
  logic [7:0]  bias_c, w_col_c, vec_out_c;
  logic [0:0]  w_addr_c;
  // D: defaults DATA_W=32, IN=4, OUT=4, FRAC=0
  logic         start_d, busy_d, done_d;
  logic [127:0] vec_in_d, bias_d, w_col_d, vec_out_d;
  logic [1:0]   w_addr_d;

  int cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;

  // Weight ROMs: W_a = [[1,2],[4,5]]; w_b fixed per test; w_c = 100; W_d[k][j] = k+j+1
  assign w_col_a = w_addr_a ? {16'd5, 16'd2} : {16'd4, 16'd1};
  assign w_col_c = (w_addr_c <= 1'b1) ? 8'd100 : 8'd0;
  always_comb begin
    w_col_d = '0;
    for (int k = 0; k < 4; k++) w_col_d[k*32 +: 32] = 32'(k + 1) + 32'(w_addr_d);
  end

  dense_layer #(.DATA_W(16), .IN_DIM(2), .OUT_DIM(2), .FRAC_W(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_in(vec_in_a), .bias(bias_a),
    .w_addr(w_addr_a), .w_col(w_col_a), .busy(busy_a), .done(done_a), .vec_out(vec_out_a)
  );
  dense_layer #(.DATA_W(16), .IN_DIM(1), .OUT_DIM(1), .FRAC_W(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_in(vec_in_b), .bias(bias_b),
    .w_addr(w_addr_b), .w_col(w_col_b), .busy(busy_b), .done(done_b), .vec_out(vec_out_b)
  );
  dense_layer #(.DATA_W(8), .IN_DIM(2), .OUT_DIM(1), .FRAC_W(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .vec_in(vec_in_c), .bias(bias_c),
    .w_addr(w_addr_c), .w_col(w_col_c), .busy(busy_c), .done(done_c), .vec_out(vec_out_c)
  );
  dense_layer u_d (
    .clk(clk), .rst(rst), .start(start_d), .vec_in(vec_in_d), .bias(bias_d),
    .w_addr(w_addr_d), .w_col(w_col_d), .busy(busy_d), .done(done_d), .vec_out(vec_out_d)
  );

  always @(posedge clk) begin
    if (done_a) cnt_a <= cnt_a + 1;
    if (done_b) cnt_b <= cnt_b + 1;
    if (done_c) cnt_c <= cnt_c + 1;
    if (done_d) cnt_d <= cnt_d + 1;
  end

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag);
    for (int k = 0; k < 4; k++) begin
      check_eq(tag, $signed(vec_out_d[k*32 +: 32]), 64'(31 + 11 * k));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {start_a, start_b, start_c, start_d} = '0;
    vec_in_a = {16'hFFFE, 16'd3};        // x = [3, -2]
    bias_a   = {16'hFFFF, 16'd10};       // b = [10, -1]
    vec_in_b = 16'd32; w_col_b = 16'd48; bias_b = 16'd16;
    vec_in_c = {8'd100, 8'd100}; bias_c = 8'd0;
    vec_in_d = {32'd4, 32'd3, 32'd2, 32'd1};
    bias_d   = {32'd4, 32'd3, 32'd2, 32'd1};
    tick(2);
    check_eq("rst_vec_out_a", vec_out_a, 0);
    check_eq("rst_busy_a", busy_a, 0);
    check_eq("rst_done_a", done_a, 0);
    check_eq("rst_w_addr_a", w_addr_a, 0);
    check_eq("rst_vec_out_d", (vec_out_d == '0) ? 1 : 0, 1);
    rst = 1'b0;
    tick();

    // Basic run with cycle-exact handshake and address sequence
    start_a = 1'b1; tick(); start_a = 1'b0;
    check_eq("a_busy_mac0", busy_a, 1);
    check_eq("a_waddr0", w_addr_a, 0);
    tick();
    check_eq("a_waddr1", w_addr_a, 1);
    tick();
    check_eq("a_waddr_fin", w_addr_a, 0);
    check_eq("a_no_early_done", done_a, 0);
    tick();
    check_eq("a_done", done_a, 1);
    check_eq("a_y0", $signed(vec_out_a[15:0]), 9);
    check_eq("a_y1", $signed(vec_out_a[31:16]), 1);
    tick();
    check_eq("a_done_pulse", done_a, 0);
    check_eq("a_busy_idle", busy_a, 0);
    check_eq("a_done_count", cnt_a, 1);

    // Fixed point: 2.0 * 3.0 + 1.0 = 7.0 (Q.4)
    start_b = 1'b1; tick(); start_b = 1'b0; tick(4);
    check_eq("b_frac", $signed(vec_out_b), 112);
    check_eq("b_done_count", cnt_b, 1);
    // Floor toward -inf: -1/16 -> -1
    vec_in_b = 16'hFFFF; w_col_b = 16'd1; bias_b = 16'd0;
    start_b = 1'b1; tick(); start_b = 1'b0; tick(4);
    check_eq("b_floor", $signed(vec_out_b), -1);
    check_eq("b_waddr", w_addr_b, 0);
    check_eq("b_done_count2", cnt_b, 2);

    // Narrowing of 20000 into 8 bits
    start_c = 1'b1; tick(); start_c = 1'b0; tick(5);
`ifdef DENSE_SAT_EN
    check_eq("c_narrow", $signed(vec_out_c), 127);
`else
    check_eq("c_narrow", $signed(vec_out_c), 32);
`endif
    check_eq("c_waddr", w_addr_c, 0);
    check_eq("c_done_count", cnt_c, 1);

    // start during MAC and DONE is ignored; x = [1,1] -> [13, 8]
    vec_in_a = {16'd1, 16'd1};
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); start_a = 1'b1;              // sampled in MAC
    tick(); start_a = 1'b0;
    check_eq("a_hold_y0", $signed(vec_out_a[15:0]), 9);
    check_eq("a_hold_y1", $signed(vec_out_a[31:16]), 1);
    tick();
    check_eq("a2_done", done_a, 1);
    start_a = 1'b1;                      // sampled in DONE
    tick(); start_a = 1'b0;
    tick(5);
    check_eq("a2_busy", busy_a, 0);
    check_eq("a2_done_count", cnt_a, 2);
    check_eq("a2_y0", $signed(vec_out_a[15:0]), 13);
    check_eq("a2_y1", $signed(vec_out_a[31:16]), 8);

    // Default-size run, then reset in the middle of MAC
    start_d = 1'b1; tick(); start_d = 1'b0; tick(6);
    check_d("d_y");
    check_eq("d_done_count", cnt_d, 1);
    start_d = 1'b1; tick(); start_d = 1'b0; tick();
    check_eq("d_mid_idx", w_addr_d, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("d_rst_vec_out", (vec_out_d == '0) ? 1 : 0, 1);
    check_eq("d_rst_busy", busy_d, 0);
    check_eq("d_rst_waddr", w_addr_d, 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check_eq("d_rst_no_done", cnt_d, 1);
    check_eq("d_rst_hold_zero", (vec_out_d == '0) ? 1 : 0, 1);
    start_d = 1'b1; tick(); start_d = 1'b0; tick(6);
    check_d("d_y_after_rst");
    check_eq("d_done_count2", cnt_d, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
